// File: rtl/inv_chain_test_sequencer.sv
// Stimulus/response sequencer for an analog inverter-chain macro: drives one bit per vector,
// checks the synchronised response polarity within a settle window and tallies results.
// Optional INV_SEQ_LFSR_EN: step the pattern as an 8-bit LFSR instead of rotating it.
module inv_chain_test_sequencer #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       pattern,
    input  logic             invert_exp,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] max_delay
);

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [7:0]       pat_reg;
    logic [7:0]       pat_next;
    logic [7:0]       pat_seed;
    logic [7:0]       vec_idx_reg;
    logic [7:0]       wait_cnt_reg;
    logic             inv_reg;
    logic             exp_reg;
    logic             trans_reg;
    logic             stim_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_reg;
    logic [CNT_W-1:0] max_delay_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic             resp_s;

    // resp_in is asynchronous to clk, so it crosses through a plain flop chain
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= resp_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign resp_s = sync_reg[SYNC_STAGES-1];

`ifdef INV_SEQ_LFSR_EN
    // x^8+x^6+x^5+x^4+1, shifting right; an all-zero seed would lock up, so force it to 1
    assign pat_next = {pat_reg[0] ^ pat_reg[2] ^ pat_reg[3] ^ pat_reg[4], pat_reg[7:1]};
    assign pat_seed = (pattern == 8'h00) ? 8'h01 : pattern;
`else
    assign pat_next = {pat_reg[0], pat_reg[7:1]};
    assign pat_seed = pattern;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pat_reg       <= '0;
            vec_idx_reg   <= '0;
            wait_cnt_reg  <= '0;
            inv_reg       <= 1'b0;
            exp_reg       <= 1'b0;
            trans_reg     <= 1'b0;
            stim_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            max_delay_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        pass_cnt_reg  <= '0;
                        fail_cnt_reg  <= '0;
                        max_delay_reg <= '0;
                        pat_reg       <= pat_seed;
                        inv_reg       <= invert_exp;
                        vec_idx_reg   <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        stim_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        stim_reg     <= pat_reg[0];
                        exp_reg      <= pat_reg[0] ^ inv_reg;
                        trans_reg    <= (pat_reg[0] != stim_reg);
                        wait_cnt_reg <= '0;
                        state_reg    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        stim_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (resp_s == exp_reg) begin
                        pass_cnt_reg <= sat_inc(pass_cnt_reg);
                        // only edges say anything about chain delay; steady vectors match at once
                        if (trans_reg && (CNT_W'(wait_cnt_reg) > max_delay_reg))
                            max_delay_reg <= CNT_W'(wait_cnt_reg);
                        state_reg <= S_NEXT;
                    end else if (wait_cnt_reg == 8'(SETTLE_CYCLES - 1)) begin
                        fail_cnt_reg <= sat_inc(fail_cnt_reg);
                        state_reg    <= S_NEXT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        stim_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        pat_reg <= pat_next;
                        if (vec_idx_reg == 8'(NUM_VECTORS - 1)) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            vec_idx_reg <= vec_idx_reg + 8'd1;
                            state_reg   <= S_DRIVE;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign stim_out  = stim_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign pass_cnt  = pass_cnt_reg;
    assign fail_cnt  = fail_cnt_reg;
    assign max_delay = max_delay_reg;

endmodule
